// File: rtl/axi4_mem_responder_pkg.sv
// rtl/axi4_mem_responder_pkg.sv - shared AXI constants, FSM state types and address helper
package axi4_mem_responder_pkg;

  localparam int         AXI_ID_W       = 4;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} write_state_t;
  typedef enum logic       {R_IDLE, R_DATA}         read_state_t;

  // Word offset from the window base; callers truncate to their index width.
  function automatic logic [31:0] word_offset(input logic [31:0] addr, input logic [31:0] base);
    return (addr - base) >> 2;
  endfunction

endpackage

// File: rtl/axi4_mem_responder_if.sv
// rtl/axi4_mem_responder_if.sv - AXI4 bus bundle, 32-bit data and address
interface axi4_mem_responder_if;
  import axi4_mem_responder_pkg::*;

  logic [AXI_ID_W-1:0] awid;
  logic [31:0]         awaddr;
  logic [7:0]          awlen;
  logic [2:0]          awsize;
  logic [1:0]          awburst;
  logic                awvalid;
  logic                awready;
  logic [31:0]         wdata;
  logic [3:0]          wstrb;
  logic                wlast;
  logic                wvalid;
  logic                wready;
  logic [AXI_ID_W-1:0] bid;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [AXI_ID_W-1:0] arid;
  logic [31:0]         araddr;
  logic [7:0]          arlen;
  logic [2:0]          arsize;
  logic [1:0]          arburst;
  logic                arvalid;
  logic                arready;
  logic [AXI_ID_W-1:0] rid;
  logic [31:0]         rdata;
  logic [1:0]          rresp;
  logic                rlast;
  logic                rvalid;
  logic                rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid, input awready,
    output wdata, wstrb, wlast, wvalid, input wready,
    input bid, bresp, bvalid, output bready,
    output arid, araddr, arlen, arsize, arburst, arvalid, input arready,
    input rid, rdata, rresp, rlast, rvalid, output rready
  );

  // Size and burst type are not listed: the responder treats every beat as a 4-byte INCR.
  modport slave (
    input awid, awaddr, awlen, awvalid, output awready,
    input wdata, wstrb, wlast, wvalid, output wready,
    output bid, bresp, bvalid, input bready,
    input arid, araddr, arlen, arvalid, output arready,
    output rid, rdata, rresp, rlast, rvalid, input rready
  );

endinterface

// File: rtl/axi4_mem_array.sv
// rtl/axi4_mem_array.sv - simple dual-port RAM, byte-enable write, registered read
module axi4_mem_array #(
  parameter int DEPTH_WORDS = 4096,
  parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [3:0]       be,
  input  logic [IDX_W-1:0] waddr,
  input  logic [31:0]      wdata,
  input  logic             re,
  input  logic [IDX_W-1:0] raddr,
  output logic [31:0]      rdata
);

  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] rdata_q;

  // Read and write in one block: a same-edge read sees the pre-write word.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
    if (re) rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/axi4_mem_responder.sv
// rtl/axi4_mem_responder.sv - AXI4 slave backed by word-addressed RAM, one write and one read burst in flight
module axi4_mem_responder
  import axi4_mem_responder_pkg::*;
#(
  parameter int          DEPTH_WORDS  = 4096,
  parameter logic [31:0] ADDR_OFFSET  = 32'h0000_0100,
  parameter bit          IGNORE_WSTRB = 1'b1,
  parameter int          STALL_PERIOD = 0
) (
  input  logic                clk,
  input  logic                reset,
  axi4_mem_responder_if.slave axi,
  output logic                wlast_err
);

  localparam int               IDX_W   = $clog2(DEPTH_WORDS);
  localparam int               SC_W    = (STALL_PERIOD > 1) ? $clog2(STALL_PERIOD) : 1;
  localparam logic [SC_W-1:0]  SC_LAST = SC_W'(STALL_PERIOD - 1);
  localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);

  logic                init_q, init_d;
  logic [SC_W-1:0]     stall_cnt_q, stall_cnt_d;
  logic                stall;

  write_state_t        w_state_q, w_state_d;
  logic [IDX_W-1:0]    w_idx_q, w_idx_d;
  logic [8:0]          w_cnt_q, w_cnt_d, w_len_q, w_len_d;
  logic [AXI_ID_W-1:0] bid_q, bid_d;
  logic                wlast_err_q, wlast_err_d;

  read_state_t         r_state_q, r_state_d;
  logic [IDX_W-1:0]    r_idx_q, r_idx_d;
  logic [8:0]          r_cnt_q, r_cnt_d, r_len_q, r_len_d;
  logic [AXI_ID_W-1:0] rid_q, rid_d;

  logic                mem_we, mem_re;
  logic [3:0]          mem_be;
  logic [IDX_W-1:0]    mem_raddr;
  logic [31:0]         mem_rdata;

  // init_q keeps the ready outputs low through the first edge after reset release.
  always_comb begin
    init_d      = 1'b1;
    stall_cnt_d = '0;
    if (STALL_PERIOD > 1 && stall_cnt_q != SC_LAST) stall_cnt_d = stall_cnt_q + SC_W'(1);
    stall       = (STALL_PERIOD > 1) && (stall_cnt_q == SC_LAST);
  end

  always_comb begin
    w_state_d   = w_state_q;
    w_idx_d     = w_idx_q;
    w_cnt_d     = w_cnt_q;
    w_len_d     = w_len_q;
    bid_d       = bid_q;
    wlast_err_d = wlast_err_q;
    axi.awready = 1'b0;
    axi.wready  = 1'b0;
    axi.bvalid  = 1'b0;
    axi.bresp   = AXI_RESP_OKAY;
    axi.bid     = bid_q;
    mem_we      = 1'b0;
    mem_be      = IGNORE_WSTRB ? 4'hF : axi.wstrb;
    case (w_state_q)
      W_IDLE: begin
        axi.awready = init_q && !stall;
        if (axi.awvalid && init_q && !stall) begin
          w_idx_d   = IDX_W'(word_offset(axi.awaddr, ADDR_OFFSET));
          w_len_d   = {1'b0, axi.awlen};
          w_cnt_d   = '0;
          bid_d     = axi.awid;
          w_state_d = W_DATA;
        end
      end
      W_DATA: begin
        axi.wready = !stall;
        if (axi.wvalid && !stall) begin
          mem_we  = 1'b1;
          w_idx_d = w_idx_q + IDX_ONE;
          w_cnt_d = w_cnt_q + 9'd1;
          // Burst length comes from awlen; wlast is only audited.
          if (axi.wlast != (w_cnt_q == w_len_q)) wlast_err_d = 1'b1;
          if (w_cnt_q == w_len_q) w_state_d = W_RESP;
        end
      end
      W_RESP: begin
        axi.bvalid = 1'b1;
        if (axi.bready) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    r_state_d   = r_state_q;
    r_idx_d     = r_idx_q;
    r_cnt_d     = r_cnt_q;
    r_len_d     = r_len_q;
    rid_d       = rid_q;
    axi.arready = 1'b0;
    axi.rvalid  = 1'b0;
    axi.rlast   = 1'b0;
    axi.rdata   = '0;
    axi.rresp   = AXI_RESP_OKAY;
    axi.rid     = rid_q;
    mem_re      = 1'b0;
    mem_raddr   = r_idx_q + IDX_ONE;
    case (r_state_q)
      R_IDLE: begin
        axi.arready = init_q && !stall;
        if (axi.arvalid && init_q && !stall) begin
          mem_raddr = IDX_W'(word_offset(axi.araddr, ADDR_OFFSET));
          mem_re    = 1'b1;
          r_idx_d   = mem_raddr;
          r_len_d   = {1'b0, axi.arlen};
          r_cnt_d   = '0;
          rid_d     = axi.arid;
          r_state_d = R_DATA;
        end
      end
      R_DATA: begin
        // The RAM output register only moves on a handshake, so rdata holds under backpressure.
        axi.rvalid = 1'b1;
        axi.rdata  = mem_rdata;
        axi.rlast  = (r_cnt_q == r_len_q);
        if (axi.rready) begin
          if (r_cnt_q == r_len_q) begin
            r_state_d = R_IDLE;
          end else begin
            mem_re  = 1'b1;
            r_idx_d = r_idx_q + IDX_ONE;
            r_cnt_d = r_cnt_q + 9'd1;
          end
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      init_q      <= 1'b0;
      stall_cnt_q <= '0;
      w_state_q   <= W_IDLE;
      w_idx_q     <= '0;
      w_cnt_q     <= '0;
      w_len_q     <= '0;
      bid_q       <= '0;
      wlast_err_q <= 1'b0;
      r_state_q   <= R_IDLE;
      r_idx_q     <= '0;
      r_cnt_q     <= '0;
      r_len_q     <= '0;
      rid_q       <= '0;
    end else begin
      init_q      <= init_d;
      stall_cnt_q <= stall_cnt_d;
      w_state_q   <= w_state_d;
      w_idx_q     <= w_idx_d;
      w_cnt_q     <= w_cnt_d;
      w_len_q     <= w_len_d;
      bid_q       <= bid_d;
      wlast_err_q <= wlast_err_d;
      r_state_q   <= r_state_d;
      r_idx_q     <= r_idx_d;
      r_cnt_q     <= r_cnt_d;
      r_len_q     <= r_len_d;
      rid_q       <= rid_d;
    end
  end

  assign wlast_err = wlast_err_q;

  axi4_mem_array #(.DEPTH_WORDS(DEPTH_WORDS), .IDX_W(IDX_W)) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .be    (mem_be),
    .waddr (w_idx_q),
    .wdata (axi.wdata),
    .re    (mem_re),
    .raddr (mem_raddr),
    .rdata (mem_rdata)
  );

endmodule

// File: tb/tb_axi4_mem_responder.sv
// tb/tb_axi4_mem_responder.sv - scoreboard bench for axi4_mem_responder
module tb_axi4_mem_responder;
  import axi4_mem_responder_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0_n, rst1_n, wlast_err0, wlast_err1;

  axi4_mem_responder_if ax0();
  axi4_mem_responder_if ax1();

  axi4_mem_responder dut0 (.clk(clk), .reset(rst0_n), .axi(ax0), .wlast_err(wlast_err0));
  axi4_mem_responder #(.DEPTH_WORDS(16), .ADDR_OFFSET(32'h100), .IGNORE_WSTRB(1'b0), .STALL_PERIOD(4))
    dut1 (.clk(clk), .reset(rst1_n), .axi(ax1), .wlast_err(wlast_err1));

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] model [2][4096];
  logic [32:0] rq[$];
  logic [AXI_ID_W-1:0] bq[$];
  int dep[2] = '{4096, 16};
  bit ign[2] = '{1'b1, 1'b0};

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic init_bus(input int d);
    virtual axi4_mem_responder_if vif;
    if (d == 0) vif = ax0; else vif = ax1;
    vif.awid = '0; vif.awaddr = '0; vif.awlen = '0; vif.awsize = 3'd2; vif.awburst = AXI_BURST_INCR;
    vif.awvalid = 1'b0; vif.wdata = '0; vif.wstrb = 4'hF; vif.wlast = 1'b0; vif.wvalid = 1'b0;
    vif.bready = 1'b1; vif.arid = '0; vif.araddr = '0; vif.arlen = '0; vif.arsize = 3'd2;
    vif.arburst = AXI_BURST_INCR; vif.arvalid = 1'b0; vif.rready = 1'b0;
  endtask

  task automatic aw_phase(input int d, input logic [31:0] addr, input int len);
    virtual axi4_mem_responder_if vif;
    int t = 0;
    if (d == 0) vif = ax0; else vif = ax1;
    vif.awid = AXI_ID_W'(len + d + 1);
    bq.push_back(vif.awid);
    vif.awaddr = addr; vif.awlen = 8'(len); vif.awvalid = 1'b1;
    while (!vif.awready && t < 600) begin @(negedge clk); t++; end
    chk("awready_seen", vif.awready, 1);
    @(negedge clk);
    vif.awvalid = 1'b0;
  endtask

  task automatic w_phase(input int d, input logic [31:0] addr, input int len,
                         input logic [31:0] base, input logic [3:0] strb, input bit bad_last);
    virtual axi4_mem_responder_if vif;
    int unsigned idx;
    int t;
    if (d == 0) vif = ax0; else vif = ax1;
    for (int i = 0; i <= len; i++) begin
      vif.wdata = base + i; vif.wstrb = strb; vif.wlast = (i == len) && !bad_last; vif.wvalid = 1'b1;
      t = 0;
      while (!vif.wready && t < 600) begin @(negedge clk); t++; end
      chk("wready_seen", vif.wready, 1);
      @(negedge clk);
      idx = ((((addr - 32'h100) >> 2)) + i) % dep[d];
      for (int b = 0; b < 4; b++)
        if (ign[d] || strb[b]) model[d][idx][8*b +: 8] = vif.wdata[8*b +: 8];
    end
    vif.wvalid = 1'b0; vif.wlast = 1'b0;
    chk("bvalid_after_last", vif.bvalid, 1);
    chk("bresp", vif.bresp, AXI_RESP_OKAY);
    chk("bid", vif.bid, bq.pop_front());
    @(negedge clk);
    chk("bvalid_drop", vif.bvalid, 0);
  endtask

  task automatic axi_write(input int d, input logic [31:0] addr, input int len,
                           input logic [31:0] base, input logic [3:0] strb);
    aw_phase(d, addr, len);
    w_phase(d, addr, len, base, strb, 1'b0);
  endtask

  task automatic axi_read(input int d, input logic [31:0] addr, input int len,
                          input bit toggle, input int abort_at);
    virtual axi4_mem_responder_if vif;
    logic [32:0] e, held;
    logic [AXI_ID_W-1:0] id;
    bit held_v = 1'b0;
    int got = 0;
    int t = 0;
    if (d == 0) vif = ax0; else vif = ax1;
    for (int i = 0; i <= len; i++)
      rq.push_back({(i == len), model[d][((((addr - 32'h100) >> 2)) + i) % dep[d]]});
    id = AXI_ID_W'(len + 2 * d + 3);
    vif.arid = id; vif.araddr = addr; vif.arlen = 8'(len); vif.arvalid = 1'b1;
    while (!vif.arready && t < 600) begin @(negedge clk); t++; end
    chk("arready_seen", vif.arready, 1);
    @(negedge clk);
    vif.arvalid = 1'b0;
    chk("rvalid_first", vif.rvalid, 1);
    t = 0;
    while (got <= len && t < 3000) begin
      if (held_v) chk("r_hold", {vif.rlast, vif.rdata}, held);
      held_v = 1'b0;
      if (abort_at >= 0 && got == abort_at) begin
        vif.rready = 1'b0;
        return;
      end
      vif.rready = toggle ? (t % 2 == 0) : 1'b1;
      if (vif.rvalid && vif.rready) begin
        e = rq.pop_front();
        chk("rdata", vif.rdata, e[31:0]);
        chk("rlast", vif.rlast, e[32]);
        chk("rid", vif.rid, id);
        got++;
      end else if (vif.rvalid) begin
        held = {vif.rlast, vif.rdata};
        held_v = 1'b1;
      end
      @(negedge clk);
      t++;
    end
    vif.rready = 1'b0;
    chk("r_beats", got, len + 1);
    chk("rvalid_end", vif.rvalid, 0);
  endtask

  // Dut1 stalls one cycle in four: ready low exactly every 4th sample.
  task automatic stall_pattern(input bit wchan);
    int first = -1;
    logic s, s2, exp;
    for (int i = 0; i < 12; i++) begin
      s  = wchan ? ax1.wready : ax1.arready;
      s2 = wchan ? ax1.wready : ax1.awready;
      if (first < 0 && !s) first = i;
      exp = (first < 0) ? 1'b1 : ((i - first) % 4 != 0);
      chk(wchan ? "wready_stall" : "arready_stall", s, exp);
      chk(wchan ? "wready_stall2" : "awready_stall", s2, exp);
      @(negedge clk);
    end
    chk("stall_in_first4", (first >= 0 && first < 4), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    init_bus(0); init_bus(1);
    rst0_n = 1'b0; rst1_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_awready", ax0.awready, 0); chk("rst_wready", ax0.wready, 0);
    chk("rst_arready", ax0.arready, 0); chk("rst_bvalid", ax0.bvalid, 0);
    chk("rst_rvalid", ax0.rvalid, 0);   chk("rst_rlast", ax0.rlast, 0);
    chk("rst_rdata", ax0.rdata, 0);     chk("rst_bid", ax0.bid, 0);
    chk("rst_rid", ax0.rid, 0);         chk("rst_resp", {ax0.bresp, ax0.rresp}, 0);
    chk("rst_wlast_err", wlast_err0, 0);
    rst0_n = 1'b1; rst1_n = 1'b1;
    #1 chk("arready_cycle1", ax0.arready, 0);
    @(negedge clk);
    chk("arready_cycle2", ax0.arready, 1);

    axi_write(0, 32'h100, 3, 32'hA0, 4'hF);
    axi_read(0, 32'h100, 3, 1'b0, -1);

    axi_write(0, 32'h500, 255, 32'h1000_0000, 4'hF);
    axi_read(0, 32'h500, 255, 1'b0, -1);
    chk("wlast_err0_clean", wlast_err0, 0);

    axi_read(0, 32'h100, 3, 1'b1, -1);

    axi_write(1, 32'h114, 0, 32'h1234_5678, 4'hF);
    axi_write(1, 32'h114, 0, 32'hDEAD_BEEF, 4'h0);
    axi_read(1, 32'h114, 0, 1'b0, -1);
    axi_write(0, 32'h120, 0, 32'hDEAD_BEEF, 4'h0);
    axi_read(0, 32'h120, 0, 1'b0, -1);

    axi_write(1, 32'h138, 3, 32'hB0, 4'hF);
    axi_read(1, 32'h100, 1, 1'b0, -1);
    axi_read(1, 32'h138, 1, 1'b1, -1);

    axi_write(0, 32'h200, 7, 32'hC0, 4'hF);
    axi_read(0, 32'h200, 7, 1'b0, 2);
    #2 rst0_n = 1'b0;
    #1 chk("midrst_rvalid", ax0.rvalid, 0);
    chk("midrst_rdata", ax0.rdata, 0);
    rq.delete();
    @(negedge clk);
    rst0_n = 1'b1;
    #1 chk("rel_arready_c1", ax0.arready, 0);
    @(negedge clk);
    chk("rel_arready_c2", ax0.arready, 1);
    axi_read(0, 32'h200, 7, 1'b0, -1);

    stall_pattern(1'b0);
    aw_phase(1, 32'h120, 1);
    stall_pattern(1'b1);
    w_phase(1, 32'h120, 1, 32'hE0, 4'hF, 1'b0);
    chk("wlast_err1_clean", wlast_err1, 0);
    aw_phase(1, 32'h120, 1);
    w_phase(1, 32'h120, 1, 32'hF0, 4'hF, 1'b1);
    chk("wlast_err1_set", wlast_err1, 1);
    axi_read(1, 32'h120, 1, 1'b0, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/axi4_mem_responder.md
Name: axi4_mem_responder

Overview:
- AXI4 slave (responder) with an internal word-addressed memory; the counterpart of the MIG adapter's AXI4 master port.
- Used as a DRAM/MIG stand-in in simulation, and as on-chip BRAM backing on boards without external DRAM.
- Write and read channels run independently: one outstanding write burst and one outstanding read burst, INCR bursts only, 32-bit beats.
- Optional periodic ready-stall injection exercises master-side flow control.

Parameters:
DEPTH_WORDS, 4096, memory size in 32-bit words; power of two
ADDR_OFFSET, 32'h00000100, byte offset subtracted from awaddr/araddr before indexing
IGNORE_WSTRB, 1, 1 = every accepted beat writes all 4 bytes; 0 = honour wstrb per byte
STALL_PERIOD, 0, 0 = never stall; N>1 = awready/wready/arready forced low one cycle in every N

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
axi  interface  -  AXI4_Std.slave modport, 32-bit data, 32-bit address

Behaviour:
- Reset: while reset is low and on the first clk edge after release:
  - awready, wready, arready, bvalid, rvalid, rlast = 0; bresp/rresp = 0; rdata = 0; bid/rid = 0.
  - Both FSMs return to idle.
  - Memory contents are not cleared.
  - Reset mid-burst abandons the burst; no partial response is issued.
- Address mapping:
  - word index = ((addr - ADDR_OFFSET) >> 2) mod DEPTH_WORDS; wraps silently, no error response.
  - awsize/arsize ignored; every beat is 4 bytes; address advances 1 word per beat.
  - awburst/arburst ignored; treated as INCR.
- Stall counter: free-running, mod STALL_PERIOD; stall = (STALL_PERIOD>1) && (count == STALL_PERIOD-1).
- Write FSM W_IDLE -> W_DATA -> W_RESP -> W_IDLE:
  - W_IDLE: awready = !stall. On awvalid&&awready: latch word index, awlen into beat counter, awid. Go to W_DATA.
  - W_DATA: wready = !stall. Each wvalid&&wready writes wdata at the current index, then index+1 (wrap).
    - After awlen+1 beats go to W_RESP; wlast is not used for termination.
    - wlast mismatch (wlast on a beat other than the last, or absent on the last) sets the sticky status flag wlast_err, visible to the bench only.
  - W_RESP: bvalid=1, bresp=OKAY(0), bid=latched awid. Hold until bready, then go to W_IDLE.
  - Earliest next awready is the cycle after the B handshake.
- Read FSM R_IDLE -> R_DATA -> R_IDLE:
  - R_IDLE: arready = !stall. On arvalid&&arready: latch index, arlen, arid. Registered memory read of the first word.
  - R_DATA:
    - rvalid asserts one cycle after the AR handshake.
    - rdata, rid and rlast are held stable while rvalid && !rready.
    - On rvalid&&rready: advance index, load the next word the same edge; rvalid stays high with no bubble.
    - rlast=1 on beat arlen only. rresp always OKAY.
    - After the last handshake: rvalid=0, go to R_IDLE.
- Same-edge read and write to the same word: the write commits; the read returns the pre-write value.
- Widths:
  - Beat counters are 9 bits (awlen/arlen up to 255, 256 beats).
  - Index is $clog2(DEPTH_WORDS) bits; the subtraction is done in 32 bits, then truncated.
- Byte enables: with IGNORE_WSTRB=0 and wstrb=0 the beat is accepted and counted, but no byte is written. The MIG adapter drives wstrb=0, so it requires IGNORE_WSTRB=1.

Decomposition:
- Shared package (structures.sv): AXI_RESP_OKAY=2'b00, AXI_BURST_INCR=2'b01, write_state_t {W_IDLE,W_DATA,W_RESP}, read_state_t {R_IDLE,R_DATA}.
- Sub-module axi4_mem_array:
  - Simple dual-port RAM, DEPTH_WORDS x 32.
  - Write port: per-byte enables. Read port: registered, 1-cycle latency.
  - Infers BRAM.

Test Plan:
- AW addr 0x100 len 3, W 0xA0..0xA3 (wlast on beat 3), bready=1 -> bvalid 1 cycle after beat 3, bresp 0; AR 0x100 len 3 -> rdata A0,A1,A2,A3, rlast only on 4th beat, first rvalid 1 cycle after AR.
- awlen=255 write of incrementing data from 0x500, then arlen=255 read -> 256 beats match, rlast on beat 255, wlast_err=0.
- rready toggled 1/0 every cycle during a 4-beat read -> each beat held stable while rready=0, no beat lost or duplicated.
- IGNORE_WSTRB=0, wstrb=0, write 0xDEADBEEF over a word holding 0x12345678 -> readback 0x12345678; IGNORE_WSTRB=1 -> 0xDEADBEEF.
- DEPTH_WORDS=16, write len 3 starting at word 14 -> words 14,15,0,1 written; read from word 0 returns the 3rd beat's data.
- reset low mid-read (beat 2 of 8) -> rvalid=0 immediately; after release, arready=1 on cycle 2 and previously written data intact; STALL_PERIOD=4 -> arready/awready/wready low exactly every 4th cycle.
